// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM sequencing the shared ALU, register file, PC/IR and memory port
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       mem_ready,
  input  logic       alu_zero,
  input  logic       alu_movn,
  input  logic       alu_overflow,
  output logic [4:0] alu_operation,
  output logic       alu_equal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zero_ext,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_instr,
  output logic       overflow_trap
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
  } state_t;
  state_t state, next, dec_state;
  logic       r_ok;
  logic [4:0] r_op, i_op;
  logic       movn;
  assign movn = funct == 6'h0B;
  always_comb begin
    r_ok = 1'b1;
    r_op = 5'd3;
    case (funct)
      6'h20: r_op = 5'd2;
      6'h21: r_op = 5'd3;
      6'h22: r_op = 5'd6;
      6'h23: r_op = 5'd7;
      6'h24: r_op = 5'd0;
      6'h25: r_op = 5'd1;
      6'h26: r_op = 5'd13;
      6'h27: r_op = 5'd12;
      6'h2A: r_op = 5'd9;
      6'h2B: r_op = 5'd10;
      6'h00: r_op = 5'd5;
      6'h02: r_op = 5'd11;
      6'h03: r_op = 5'd14;
      6'h07: r_op = 5'd16;
      6'h0B: r_op = 5'd4;
      default: r_ok = 1'b0;
    endcase
  end
  always_comb begin
    i_op = 5'd15;
    case (opcode[2:0])
      3'd0: i_op = 5'd2;
      3'd1: i_op = 5'd3;
      3'd2: i_op = 5'd9;
      3'd3: i_op = 5'd10;
      3'd4: i_op = 5'd0;
      3'd5: i_op = 5'd1;
      3'd6: i_op = 5'd13;
      default: i_op = 5'd15;
    endcase
  end
  // Undecodable instructions fall back to FETCH; DECODE flags them as illegal.
  assign dec_state = (opcode == 6'h00 && r_ok)                  ? R_EXEC   :
                     (opcode == 6'h23 || opcode == 6'h2B)       ? MEM_ADDR :
                     (opcode[5:3] == 3'b001)                    ? I_EXEC   :
                     (opcode == 6'h04 || opcode == 6'h05 ||
                      (opcode == 6'h01 && rt == 5'd1))          ? BRANCH   :
                     (opcode == 6'h02)                          ? JUMP     : FETCH;
  always_ff @(posedge clk)
    state <= rst ? FETCH : next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:     next = mem_ready ? DECODE : FETCH;
      DECODE:    next = dec_state;
      MEM_ADDR:  next = opcode == 6'h23 ? MEM_READ : MEM_WRITE;
      MEM_READ:  next = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: next = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    next = (alu_overflow || (movn && !alu_movn)) ? FETCH : R_WB;
      I_EXEC:    next = alu_overflow ? FETCH : I_WB;
      default:   next = FETCH;
    endcase
  end
  always_comb begin
    alu_operation = 5'd0;
    alu_equal     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zero_ext  = 1'b0;
    pc_source     = 2'b00;
    pc_en         = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    overflow_trap = 1'b0;
    case (state)
      FETCH: begin
        mem_read      = 1'b1;
        alu_src_b     = 2'b01;
        alu_operation = 5'd3;
        ir_write      = mem_ready;
        pc_en         = mem_ready;
      end
      DECODE: begin
        alu_src_b     = 2'b11;
        alu_operation = 5'd3;
        illegal_instr = dec_state == FETCH;
      end
      MEM_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_operation = 5'd3;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a     = 1'b1;
        alu_operation = r_op;
        overflow_trap = alu_overflow;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      I_EXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_operation = i_op;
        imm_zero_ext  = opcode[2] && !(opcode[1] && opcode[0]);
        overflow_trap = alu_overflow;
      end
      I_WB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a     = 1'b1;
        pc_source     = 2'b01;
        pc_en         = alu_zero;
        alu_operation = opcode == 6'h01 ? 5'd8 : 5'd6;
        alu_equal     = opcode == 6'h04;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
